// File: rtl/ship_hit_detect_pkg.sv
// Shared ship geometry, coordinate widths and hit-detection FSM state encoding.
// Also used by the ship drawing logic so the hit box always matches the sprite.
package ship_hit_detect_pkg;

  localparam int SHIP_HALF_WIDTH = 25;
  localparam int SHIP_HEIGHT     = 50;
  localparam int COORD_W         = 11;
  localparam int CMP_W           = 12;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } ship_state_e;

  // Left edge of the hit box, clamped at the screen edge instead of wrapping.
  function automatic logic [CMP_W-1:0] hit_box_left(input logic [COORD_W-1:0] xpos);
    if (xpos < COORD_W'(SHIP_HALF_WIDTH)) begin
      return '0;
    end
    return {1'b0, xpos} - CMP_W'(SHIP_HALF_WIDTH);
  endfunction

endpackage

// File: rtl/ship_hit_detect_if.sv
// Signal bundle between the game core and the ship hit detector.
// master drives positions and game events; slave (the detector) returns status.
interface ship_hit_detect_if;
  import ship_hit_detect_pkg::*;

  logic [COORD_W-1:0] xpos_ship;
  logic [COORD_W-1:0] ypos_ship;
  logic [COORD_W-1:0] xpos_enemy_missile;
  logic [COORD_W-1:0] ypos_enemy_missile;
  logic               on_enemy_missile;
  logic               level_change;
  logic               new_game;
  logic               hit_pulse;
  logic               ship_visible;
  logic [2:0]         lives;
  logic               game_over;

  modport master (
    output xpos_ship, ypos_ship, xpos_enemy_missile, ypos_enemy_missile,
    output on_enemy_missile, level_change, new_game,
    input  hit_pulse, ship_visible, lives, game_over
  );

  modport slave (
    input  xpos_ship, ypos_ship, xpos_enemy_missile, ypos_enemy_missile,
    input  on_enemy_missile, level_change, new_game,
    output hit_pulse, ship_visible, lives, game_over
  );

endinterface

// File: rtl/ship_hit_detect_hit_box.sv
// ship_hit_box: inclusive bounding-box test of the enemy missile tip against the
// ship, evaluated in 12-bit unsigned arithmetic and registered once.
module ship_hit_box
  import ship_hit_detect_pkg::*;
(
  input  logic               pclk,
  input  logic               rst,
  input  logic [COORD_W-1:0] xpos_ship_i,
  input  logic [COORD_W-1:0] ypos_ship_i,
  input  logic [COORD_W-1:0] xpos_missile_i,
  input  logic [COORD_W-1:0] ypos_missile_i,
  input  logic               on_missile_i,
  output logic               overlap_o
);

  logic [CMP_W-1:0] x_lo, x_hi, y_lo, y_hi, x_m, y_m;
  logic             overlap_d, overlap_q;

  always_comb begin
    x_lo = hit_box_left(xpos_ship_i);
    x_hi = {1'b0, xpos_ship_i} + CMP_W'(SHIP_HALF_WIDTH);
    y_lo = {1'b0, ypos_ship_i};
    y_hi = {1'b0, ypos_ship_i} + CMP_W'(SHIP_HEIGHT);
    x_m  = {1'b0, xpos_missile_i};
    y_m  = {1'b0, ypos_missile_i};
    overlap_d = on_missile_i
             && (x_m >= x_lo) && (x_m <= x_hi)
             && (y_m >= y_lo) && (y_m <= y_hi);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      overlap_q <= 1'b0;
    end else begin
      overlap_q <= overlap_d;
    end
  end

  assign overlap_o = overlap_q;

endmodule

// File: rtl/ship_hit_detect.sv
// Ship hit detector: lives counter, post-hit invulnerability and game-over FSM.
// Define SHIP_BLINK_EN to blink the ship while invulnerable.
module ship_hit_detect
  import ship_hit_detect_pkg::*;
#(
  parameter int LIVES         = 3,
  parameter int INVULN_CYCLES = 130_000_000,
  parameter int BLINK_CYCLES  = 8_125_000
) (
  input  logic              pclk,
  input  logic              rst,
  ship_hit_detect_if.slave  bus
);

  localparam int TIMER_W = $clog2(INVULN_CYCLES + 1);

  ship_state_e        state_q, state_d;
  logic [2:0]         lives_q, lives_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               hit_q, hit_d;
  logic               game_over_q, game_over_d;
  logic               overlap_q;
  logic               ship_visible;

  ship_hit_box u_hit_box (
    .pclk           (pclk),
    .rst            (rst),
    .xpos_ship_i    (bus.xpos_ship),
    .ypos_ship_i    (bus.ypos_ship),
    .xpos_missile_i (bus.xpos_enemy_missile),
    .ypos_missile_i (bus.ypos_enemy_missile),
    .on_missile_i   (bus.on_enemy_missile),
    .overlap_o      (overlap_q)
  );

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q     <= ALIVE;
      lives_q     <= 3'(LIVES);
      timer_q     <= '0;
      hit_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      timer_q     <= timer_d;
      hit_q       <= hit_d;
      game_over_q <= game_over_d;
    end
  end

  // new_game outranks everything, including a hit registered in the same cycle.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    timer_d     = timer_q;
    hit_d       = 1'b0;
    game_over_d = game_over_q;
    if (bus.new_game) begin
      state_d     = ALIVE;
      lives_d     = 3'(LIVES);
      timer_d     = '0;
      game_over_d = 1'b0;
    end else begin
      case (state_q)
        ALIVE: begin
          if (overlap_q) begin
            hit_d = 1'b1;
            if (lives_q > 3'd1) begin
              lives_d = lives_q - 3'd1;
              timer_d = TIMER_W'(INVULN_CYCLES - 1);
              state_d = INVULN;
            end else begin
              lives_d     = 3'd0;
              game_over_d = 1'b1;
              state_d     = DEAD;
            end
          end
        end
        INVULN: begin
          if (bus.level_change || (timer_q == '0)) begin
            timer_d = '0;
            state_d = ALIVE;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        DEAD: begin
          state_d = DEAD;
        end
        default: begin
          state_d = ALIVE;
        end
      endcase
    end
  end

`ifdef SHIP_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;

  // Blink phase restarts hidden on every INVULN entry and is cleared outside it.
  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if ((state_q == INVULN) && (state_d == INVULN)) begin
      if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_d     = blink_q;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign ship_visible = (state_q == ALIVE) || ((state_q == INVULN) && blink_q);
`else
  assign ship_visible = (state_q != DEAD);

  // Keeps BLINK_CYCLES referenced when blinking is compiled out.
  if (BLINK_CYCLES < 1) begin : g_blink_cfg_unused
  end
`endif

  assign bus.hit_pulse    = hit_q;
  assign bus.ship_visible = ship_visible;
  assign bus.lives        = lives_q;
  assign bus.game_over    = game_over_q;

endmodule

// File: tb/tb_ship_hit_detect.sv
// Self-checking bench for ship_hit_detect: directed scenarios plus random traffic
// compared every cycle against a cycle-count based game model.
module tb_ship_hit_detect;

  localparam int LIVES         = 3;
  localparam int INVULN_CYCLES = 16;
  localparam int BLINK_CYCLES  = 4;

  logic pclk = 1'b0;
  logic rst  = 1'b0;

  always #5 pclk = ~pclk;

  ship_hit_detect_if bus ();

  ship_hit_detect #(
    .LIVES         (LIVES),
    .INVULN_CYCLES (INVULN_CYCLES),
    .BLINK_CYCLES  (BLINK_CYCLES)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  int curSx, curSy, curMx, curMy, curOn, curLc, curNg;

  // Reference game state: lives left, invulnerable cycles left, delayed overlap.
  int mLives;
  int mInvulnLeft;
  int mOvQ;
  int mHit;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int refOverlap(int sx, int sy, int mx, int my, int on);
    int lo;
    lo = sx - 25;
    if (lo < 0) lo = 0;
    return ((on != 0) && (mx >= lo) && (mx <= sx + 25) && (my >= sy) && (my <= sy + 50)) ? 1 : 0;
  endfunction

  function automatic int refVisible();
    if (mLives == 0) return 0;
    if (mInvulnLeft == 0) return 1;
`ifdef SHIP_BLINK_EN
    return ((INVULN_CYCLES - mInvulnLeft) / BLINK_CYCLES) % 2;
`else
    return 1;
`endif
  endfunction

  task automatic modelReset();
    mLives      = LIVES;
    mInvulnLeft = 0;
    mOvQ        = 0;
    mHit        = 0;
  endtask

  task automatic modelStep();
    int ovNow;
    ovNow = refOverlap(curSx, curSy, curMx, curMy, curOn);
    mHit  = 0;
    if (curNg != 0) begin
      mLives      = LIVES;
      mInvulnLeft = 0;
    end else if (mLives == 0) begin
      mHit = 0;
    end else if (mInvulnLeft > 0) begin
      if (curLc != 0) mInvulnLeft = 0;
      else mInvulnLeft--;
    end else if (mOvQ != 0) begin
      mHit  = 1;
      mLives--;
      mInvulnLeft = (mLives > 0) ? INVULN_CYCLES : 0;
    end
    mOvQ = ovNow;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_hit"},     bus.hit_pulse,    mHit);
    checkOutput({tag, "_lives"},   bus.lives,        mLives);
    checkOutput({tag, "_gameover"}, bus.game_over,   (mLives == 0) ? 1 : 0);
    checkOutput({tag, "_visible"}, bus.ship_visible, refVisible());
  endtask

  task automatic runCycle(input string tag);
    @(posedge pclk);
    modelStep();
    #1;
    checkAll(tag);
  endtask

  task automatic applyStimulus(input int sx, input int sy, input int mx, input int my,
                               input int on, input int lc, input int ng, input string tag);
    curSx = sx; curSy = sy; curMx = mx; curMy = my;
    curOn = on; curLc = lc; curNg = ng;
    bus.xpos_ship          = 11'(sx);
    bus.ypos_ship          = 11'(sy);
    bus.xpos_enemy_missile = 11'(mx);
    bus.ypos_enemy_missile = 11'(my);
    bus.on_enemy_missile   = (on != 0);
    bus.level_change       = (lc != 0);
    bus.new_game           = (ng != 0);
    runCycle(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(500, 700, 0, 0, 0, 0, 0, tag);
  endtask

  function automatic int clampCoord(int v);
    if (v < 0) return 0;
    if (v > 2047) return 2047;
    return v;
  endfunction

  initial begin
    int sx, sy, mx, my;
    bus.xpos_ship = '0; bus.ypos_ship = '0;
    bus.xpos_enemy_missile = '0; bus.ypos_enemy_missile = '0;
    bus.on_enemy_missile = 1'b0; bus.level_change = 1'b0; bus.new_game = 1'b0;
    curSx = 0; curSy = 0; curMx = 0; curMy = 0; curOn = 0; curLc = 0; curNg = 0;
    modelReset();
    #22;
    checkAll("reset");
    @(negedge pclk);
    rst = 1'b1;

    // Single-cycle overlap: hit two edges later.
    applyStimulus(500, 700, 525, 750, 1, 0, 0, "req022_c1");
    applyStimulus(500, 700, 0, 0, 0, 0, 0, "req022_c2");
    checkOutput("req022_hit_at_2", bus.hit_pulse, 1);
    checkOutput("req022_lives_2", bus.lives, 2);
    applyStimulus(500, 700, 0, 0, 0, 0, 0, "req022_c3");
    checkOutput("req022_hit_once", bus.hit_pulse, 0);
    applyStimulus(500, 700, 0, 0, 0, 0, 1, "ng1");
    idle(2, "idle1");

    // Boundary misses and the clamped left edge.
    for (int i = 0; i < 3; i++) applyStimulus(500, 700, 526, 700, 1, 0, 0, "req023_xmiss");
    for (int i = 0; i < 3; i++) applyStimulus(500, 700, 500, 751, 1, 0, 0, "req023_ymiss");
    checkOutput("req023_nohit_lives", bus.lives, 3);
    applyStimulus(10, 700, 0, 700, 1, 0, 0, "req023_clamp");
    applyStimulus(10, 700, 0, 0, 0, 0, 0, "req023_clamp2");
    checkOutput("req023_clamp_hit", bus.hit_pulse, 1);
    applyStimulus(500, 700, 0, 0, 0, 0, 1, "ng2");
    idle(2, "idle2");

    // Continuous overlap through invulnerability, then into DEAD.
    for (int i = 0; i < 60; i++) applyStimulus(500, 700, 500, 720, 1, 0, 0, "req024_hold");
    checkOutput("req025_dead_lives", bus.lives, 0);
    checkOutput("req025_dead_over", bus.game_over, 1);
    checkOutput("req025_dead_vis", bus.ship_visible, 0);
    applyStimulus(500, 700, 0, 0, 0, 0, 1, "req025_ng");
    checkOutput("req025_ng_lives", bus.lives, 3);
    checkOutput("req025_ng_nohit", bus.hit_pulse, 0);
    idle(3, "idle3");

    // Reset in the middle of invulnerability.
    applyStimulus(500, 700, 500, 700, 1, 0, 0, "req026_hit");
    for (int i = 0; i < 40 && !(mInvulnLeft == 8); i++)
      applyStimulus(500, 700, 0, 0, 0, 0, 0, "req026_wait");
    rst = 1'b0;
    #2;
    modelReset();
    checkOutput("req026_rst_lives", bus.lives, 3);
    checkOutput("req026_rst_vis", bus.ship_visible, 1);
    checkAll("req026_rst");
    @(posedge pclk);
    @(negedge pclk);
    rst = 1'b1;
    idle(2, "idle4");

    // level_change cuts invulnerability short.
    applyStimulus(500, 700, 500, 700, 1, 0, 0, "lc_hit1");
    applyStimulus(500, 700, 0, 0, 0, 0, 0, "lc_hit2");
    idle(3, "lc_inv");
    applyStimulus(500, 700, 0, 0, 0, 1, 0, "lc_pulse");
    checkOutput("lc_alive_vis", bus.ship_visible, 1);
    checkOutput("lc_lives_kept", bus.lives, 2);
    applyStimulus(500, 700, 0, 0, 0, 0, 1, "ng3");

    // Random traffic around the ship.
    for (int i = 0; i < 3000; i++) begin
      sx = int'($urandom_range(0, 1900));
      sy = int'($urandom_range(0, 1900));
      if ($urandom_range(0, 7) == 0) sx = int'($urandom_range(0, 30));
      mx = clampCoord(sx + int'($urandom_range(0, 70)) - 35);
      my = clampCoord(sy + int'($urandom_range(0, 60)) - 5);
      applyStimulus(sx, sy, mx, my,
                    ($urandom_range(0, 3) != 0) ? 1 : 0,
                    ($urandom_range(0, 15) == 0) ? 1 : 0,
                    ($urandom_range(0, 63) == 0) ? 1 : 0,
                    "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
